// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_pkg
// Description : Shared definitions for the SPI ADC capture block: frame
//               geometry and the capture FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_pkg;

    localparam int FRAME_BITS = 16;   // adc_sclk periods per conversion frame
    localparam int LEAD_BITS  = 4;    // leading bits that must read as zero
    localparam int DATA_W     = 12;   // conversion result width

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CS_SETUP = 3'd1,
        SHIFT    = 3'd2,
        CS_HOLD  = 3'd3,
        GAP      = 3'd4
    } adc_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for a single asynchronous input bit.
// Ports       : PCLK    - destination clock
//               PRESETn - asynchronous active-low reset, clears both flops
//               d       - asynchronous input
//               q       - synchronized output
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/adc_spi_capture.sv
`default_nettype none
// ============================================================================
// Module      : adc_spi_capture
// Description : SPI master that repeatedly reads a 16-bit frame from a serial
//               ADC and publishes the low 12 bits as a conversion result.
// Parameters  : CLK_DIV  - PCLK cycles per adc_sclk half-period (3..255)
//               CONV_GAP - PCLK cycles spent in GAP after a frame (1..65535)
// Ports       : PCLK, PRESETn   - clock, asynchronous active-low reset
//               sample_enable   - continuous-conversion request
//               adc_cs_n        - ADC chip select, active low
//               adc_sclk        - ADC serial clock, idle high
//               adc_sdata       - ADC serial data, MSB first, asynchronous
//               ADC_DATA        - last completed conversion result
//               adc_valid       - one-cycle pulse when ADC_DATA updates
//               adc_frame_err   - pulse with adc_valid if leading bits != 0
//               adc_busy        - high whenever the FSM is not in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module adc_spi_capture
    import adc_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CONV_GAP = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              sample_enable,
    output logic              adc_cs_n,
    output logic              adc_sclk,
    input  logic              adc_sdata,
    output logic [DATA_W-1:0] ADC_DATA,
    output logic              adc_valid,
    output logic              adc_frame_err,
    output logic              adc_busy
);

    localparam logic [7:0]  c_half_last = 8'(CLK_DIV - 1);
    localparam logic [3:0]  c_bit_last  = 4'(FRAME_BITS - 1);
    localparam logic [15:0] c_gap_last  = 16'(CONV_GAP - 1);

    adc_state_t            r_state;
    logic [7:0]            r_half_cnt;
    logic [3:0]            r_bit_cnt;
    logic [15:0]           r_gap_cnt;
    logic [FRAME_BITS-1:0] r_shift;
    logic                  r_cs_n;
    logic                  r_sclk;
    logic [DATA_W-1:0]     r_data;
    logic                  r_valid;
    logic                  r_frame_err;
    logic                  r_busy;

    logic                  w_sdata_sync;
    logic                  w_half_done;

    sync_2ff u_sync_sdata (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .d       (adc_sdata),
        .q       (w_sdata_sync)
    );

    assign w_half_done = (r_half_cnt == c_half_last);

    // Every output is a flop loaded with the value belonging to the state
    // being entered, so adc_cs_n/adc_sclk never pass through logic.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state     <= IDLE;
            r_half_cnt  <= 8'd0;
            r_bit_cnt   <= 4'd0;
            r_gap_cnt   <= 16'd0;
            r_shift     <= '0;
            r_cs_n      <= 1'b1;
            r_sclk      <= 1'b1;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (sample_enable) begin
                        r_state    <= CS_SETUP;
                        r_cs_n     <= 1'b0;
                        r_sclk     <= 1'b1;
                        r_busy     <= 1'b1;
                        r_half_cnt <= 8'd0;
                    end
                end
                CS_SETUP: begin
                    if (w_half_done) begin
                        r_state    <= SHIFT;
                        r_half_cnt <= 8'd0;
                        r_bit_cnt  <= 4'd0;
                        r_sclk     <= 1'b0;
                    end else begin
                        r_half_cnt <= r_half_cnt + 8'd1;
                    end
                end
                SHIFT: begin
                    if (w_half_done) begin
                        r_half_cnt <= 8'd0;
                        if (!r_sclk) begin
                            // End of the low phase: the ADC has had the whole
                            // phase to settle and the synchronizer has caught up.
                            r_shift <= {r_shift[FRAME_BITS-2:0], w_sdata_sync};
                            r_sclk  <= 1'b1;
                        end else if (r_bit_cnt == c_bit_last) begin
                            r_state <= CS_HOLD;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            r_sclk    <= 1'b0;
                        end
                    end else begin
                        r_half_cnt <= r_half_cnt + 8'd1;
                    end
                end
                CS_HOLD: begin
                    if (w_half_done) begin
                        r_state     <= GAP;
                        r_half_cnt  <= 8'd0;
                        r_gap_cnt   <= 16'd0;
                        r_cs_n      <= 1'b1;
                        r_data      <= r_shift[DATA_W-1:0];
                        r_valid     <= 1'b1;
                        r_frame_err <= |r_shift[FRAME_BITS-1 -: LEAD_BITS];
                    end else begin
                        r_half_cnt <= r_half_cnt + 8'd1;
                    end
                end
                GAP: begin
                    // The cycle carrying adc_valid is the first GAP cycle.
                    if (r_gap_cnt == c_gap_last) begin
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                        r_gap_cnt <= 16'd0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cs_n  <= 1'b1;
                    r_sclk  <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign adc_cs_n      = r_cs_n;
    assign adc_sclk      = r_sclk;
    assign ADC_DATA      = r_data;
    assign adc_valid     = r_valid;
    assign adc_frame_err = r_frame_err;
    assign adc_busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_spi_capture
// Description : Self-checking bench for adc_spi_capture. Instance 0 uses the
//               default parameters, instance 1 uses CLK_DIV=3, CONV_GAP=1.
//               Each instance is fed by a simple serial ADC model that shifts
//               out a 16-bit word, MSB first, on falling adc_sclk edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_spi_capture;
    import adc_pkg::*;

    localparam int D0 = 4;
    localparam int G0 = 16;
    localparam int D1 = 3;
    localparam int G1 = 1;

    logic PCLK    = 1'b0;
    logic PRESETn = 1'b0;

    logic en0 = 1'b0, en1 = 1'b0;
    logic sdata0 = 1'b0, sdata1 = 1'b0;
    logic [15:0] word0 = 16'h0, word1 = 16'h0;

    wire              cs0, sclk0, valid0, err0, busy0;
    wire              cs1, sclk1, valid1, err1, busy1;
    wire [DATA_W-1:0] data0, data1;

    int vectors     = 0;
    int miscompares = 0;

    always #5 PCLK = ~PCLK;

    adc_spi_capture #(.CLK_DIV(D0), .CONV_GAP(G0)) dut0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .sample_enable(en0),
        .adc_cs_n(cs0), .adc_sclk(sclk0), .adc_sdata(sdata0),
        .ADC_DATA(data0), .adc_valid(valid0), .adc_frame_err(err0), .adc_busy(busy0)
    );

    adc_spi_capture #(.CLK_DIV(D1), .CONV_GAP(G1)) dut1 (
        .PCLK(PCLK), .PRESETn(PRESETn), .sample_enable(en1),
        .adc_cs_n(cs1), .adc_sclk(sclk1), .adc_sdata(sdata1),
        .ADC_DATA(data1), .adc_valid(valid1), .adc_frame_err(err1), .adc_busy(busy1)
    );

    // ---------------- serial ADC models ----------------
    int   idx0 = 15, idx1 = 15;
    logic prev_sclk0 = 1'b1, prev_sclk1 = 1'b1;

    always @(negedge PCLK) begin
        if (cs0) idx0 = 15;
        else if (prev_sclk0 && !sclk0 && idx0 >= 0) begin
            sdata0 = word0[idx0];
            idx0   = idx0 - 1;
        end
        prev_sclk0 = sclk0;
    end

    always @(negedge PCLK) begin
        if (cs1) idx1 = 15;
        else if (prev_sclk1 && !sclk1 && idx1 >= 0) begin
            sdata1 = word1[idx1];
            idx1   = idx1 - 1;
        end
        prev_sclk1 = sclk1;
    end

    // ADC_DATA may only move on an adc_valid cycle.
    logic [DATA_W-1:0] hold0 = '0, hold1 = '0;
    always @(negedge PCLK) begin
        if (PRESETn && !valid0) begin
            vectors++;
            assert (data0 === hold0) else begin
                miscompares++;
                $error("FAIL data0_hold: observed %0h expected %0h", data0, hold0);
            end
        end
        if (PRESETn && !valid1) begin
            vectors++;
            assert (data1 === hold1) else begin
                miscompares++;
                $error("FAIL data1_hold: observed %0h expected %0h", data1, hold1);
            end
        end
        hold0 = data0;
        hold1 = data1;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_valid(input int s);
        return (s != 0) ? valid1 : valid0;
    endfunction

    function automatic logic get_busy(input int s);
        return (s != 0) ? busy1 : busy0;
    endfunction

    function automatic logic get_sclk(input int s);
        return (s != 0) ? sclk1 : sclk0;
    endfunction

    // Frame latency from the rules: CS setup + 16 full sclk periods + CS hold.
    function automatic int frame_latency(input int d);
        return d + FRAME_BITS * 2 * d + d;
    endfunction

    // Counts negedges until adc_valid is seen; returns -1 on timeout.
    // With pulse=1 the request is dropped after the first sampling edge.
    task automatic wait_valid(input int s, input bit pulse, input int limit, output int n);
        n = 0;
        forever begin
            @(negedge PCLK);
            n++;
            if (pulse) begin
                if (s != 0) en1 = 1'b0; else en0 = 1'b0;
            end
            if (get_valid(s)) break;
            if (n >= limit) begin
                n = -1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int s, input int limit);
        int n;
        n = 0;
        while (get_busy(s) && n < limit) begin
            @(negedge PCLK);
            n++;
        end
        check("idle_timeout", {31'd0, get_busy(s)}, 32'd0);
    endtask

    task automatic wait_falls(input int s, input int nfalls, input int limit);
        int   n, f;
        logic p;
        n = 0;
        f = 0;
        p = get_sclk(s);
        while (f < nfalls && n < limit) begin
            @(negedge PCLK);
            n++;
            if (p && !get_sclk(s)) f++;
            p = get_sclk(s);
        end
        check("fall_timeout", f, nfalls);
    endtask

    task automatic count_valids(input int s, input int cycles, output int nv);
        nv = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge PCLK);
            if (get_valid(s)) nv++;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int          n, nv, cnt;
        logic [15:0] w;

        // Reset state
        repeat (3) @(negedge PCLK);
        check("rst_cs_n",  cs0,    1);
        check("rst_sclk",  sclk0,  1);
        check("rst_data",  data0,  0);
        check("rst_valid", valid0, 0);
        check("rst_err",   err0,   0);
        check("rst_busy",  busy0,  0);
        PRESETn = 1'b1;
        repeat (2) @(negedge PCLK);

        // Single-cycle request, 0x0ABC
        word0 = 16'h0ABC;
        en0   = 1'b1;
        wait_valid(0, 1'b1, 400, n);
        // The sampling edge lies between the drive point and the first negedge.
        check("abc_latency", n - 1, frame_latency(D0));
        check("abc_data",    data0, 12'hABC);
        check("abc_err",     err0,  0);
        @(negedge PCLK);
        check("abc_valid_1cyc", valid0, 0);
        wait_idle(0, 100);
        check("abc_cs_idle", cs0, 1);
        count_valids(0, 200, nv);
        check("abc_single_frame", nv, 0);

        // Held request: 0x0001 then 0x0FFF
        word0 = 16'h0001;
        en0   = 1'b1;
        wait_valid(0, 1'b0, 400, n);
        check("hold_latency", n - 1, frame_latency(D0));
        check("hold_data1",   data0, 12'h001);
        word0 = 16'h0FFF;
        wait_valid(0, 1'b0, 400, n);
        check("hold_period",  n, frame_latency(D0) + G0 + 1);
        check("hold_data2",   data0, 12'hFFF);
        en0 = 1'b0;
        wait_idle(0, 100);

        // Malformed frame 0x8123
        word0 = 16'h8123;
        en0   = 1'b1;
        wait_valid(0, 1'b1, 400, n);
        check("err_latency", n - 1, frame_latency(D0));
        check("err_data",    data0, 12'h123);
        check("err_flag",    err0,  1);
        @(negedge PCLK);
        check("err_flag_1cyc",  err0,   0);
        check("err_valid_1cyc", valid0, 0);
        wait_idle(0, 100);

        // Random words
        for (int i = 0; i < 4; i++) begin
            w     = 16'($urandom);
            word0 = w;
            en0   = 1'b1;
            wait_valid(0, 1'b1, 400, n);
            check("rnd_latency", n - 1, frame_latency(D0));
            check("rnd_data",    data0, w[11:0]);
            check("rnd_err",     err0,  (w[15:12] != 4'h0) ? 1 : 0);
            wait_idle(0, 100);
        end

        // Request dropped during the bit-5 low phase
        word0 = 16'h05A5;
        en0   = 1'b1;
        wait_falls(0, 6, 400);
        en0 = 1'b0;
        wait_valid(0, 1'b0, 400, n);
        check("drop_valid_seen", (n > 0) ? 1 : 0, 1);
        check("drop_data", data0, 12'h5A5);
        wait_idle(0, 100);
        check("drop_busy", busy0, 0);
        check("drop_cs",   cs0,   1);
        count_valids(0, 300, nv);
        check("drop_no_new_frame", nv, 0);

        // Reset during the bit-8 low phase, request kept asserted
        word0 = 16'h0321;
        en0   = 1'b1;
        wait_falls(0, 9, 400);
        #2 PRESETn = 1'b0;
        #1;
        check("mrst_cs",    cs0,    1);
        check("mrst_sclk",  sclk0,  1);
        check("mrst_data",  data0,  0);
        check("mrst_valid", valid0, 0);
        check("mrst_busy",  busy0,  0);
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        wait_valid(0, 1'b0, 400, n);
        check("mrst_full_frame", n - 1, frame_latency(D0));
        check("mrst_data_new",   data0, 12'h321);
        en0 = 1'b0;
        wait_idle(0, 100);

        // Instance with CLK_DIV=3, CONV_GAP=1
        w     = 16'($urandom) & 16'h0FFF;
        word1 = w;
        en1   = 1'b1;
        wait_valid(1, 1'b0, 400, n);
        check("d3_latency", n - 1, frame_latency(D1));
        check("d3_data1",   data1, w[11:0]);
        w     = 16'($urandom) | 16'h1000;
        word1 = w;
        wait_valid(1, 1'b0, 400, n);
        check("d3_period", n, frame_latency(D1) + G1 + 1);
        check("d3_data2",  data1, w[11:0]);
        check("d3_err",    err1,  1);
        // Half-period measurement inside the next frame
        cnt = 0;
        while (sclk1 && cnt < 100) begin
            @(negedge PCLK);
            cnt++;
        end
        cnt = 0;
        while (!sclk1 && cnt < 100) begin
            cnt++;
            @(negedge PCLK);
        end
        check("d3_sclk_low", cnt, D1);
        cnt = 0;
        while (sclk1 && cnt < 100) begin
            cnt++;
            @(negedge PCLK);
        end
        check("d3_sclk_high", cnt, D1);
        en1 = 1'b0;
        wait_idle(1, 200);
        check("d3_cs_idle", cs1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
